led_scanner: RTL

Scan engine for a 64x64 HUB75 panel at 1/32 multiplex. It sits between the board pins and the `painter`. For each pixel it drives `x`, `y` and `frame`, samples the painter's combinational `rgb`, shifts two rows (top half and bottom half) into the panel, then latches, addresses and blanks them. It is the consumer and sequencer of the `painter` interface and the body of `led_main`.

---
 rtl/led_pkg.sv | 33 +++
 rtl/led_pixel_sequencer.sv | 53 +++++
 rtl/led_scanner.sv | 113 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// led_pkg: pin map, panel geometry and scan-state encoding shared by the led_scanner files.
// SETTLE_LEN grows from 1 to 3 cycles when LED_SCANNER_GHOST_SUPPRESS_EN is defined.
package led_pkg;
    localparam int LED_R0    = 0;
    localparam int LED_G0    = 1;
    localparam int LED_B0    = 2;
    localparam int LED_R1    = 3;
    localparam int LED_G1    = 4;
    localparam int LED_B1    = 5;
    localparam int LED_A     = 6;
    localparam int LED_B     = 7;
    localparam int LED_C     = 8;
    localparam int LED_D     = 9;
    localparam int LED_E     = 10;
    localparam int LED_SCLK  = 11;
    localparam int LED_LAT   = 12;
    localparam int LED_OE_N  = 13;
    localparam int PANEL_W   = 64;
    localparam int SCAN_ROWS = 32;
`ifdef LED_SCANNER_GHOST_SUPPRESS_EN
    localparam int SETTLE_LEN = 3;
`else
    localparam int SETTLE_LEN = 1;
`endif
    typedef enum logic [2:0] {
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_ADDR,
        ST_SETTLE,
        ST_DWELL
    } scan_state_e;
endpackage

// File: rtl/led_pixel_sequencer.sv
// led_pixel_sequencer: walks 64 columns x 4 phases for one row pair, presenting x/y to the
// painter, capturing the top then bottom colour and generating SCLK.
module led_pixel_sequencer
    import led_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [4:0] row,
    input  logic [2:0] rgb,
    output logic [5:0] x,
    output logic [5:0] y,
    output logic [5:0] pix,
    output logic       sclk,
    output logic       done
);
    logic       busy_q, busy_d;
    logic [5:0] col_q, col_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] top_q, top_d;
    logic [5:0] pix_q, pix_d;

    assign done = busy_q && col_q == 6'(PANEL_W - 1) && phase_q == 2'd3;
    assign sclk = busy_q && phase_q == 2'd3;
    assign x    = col_q;
    assign y    = {phase_q != 2'd0, row};
    assign pix  = pix_q;

    // Top half is presented in phase 0 and the bottom half in phase 1; both land on the pins together.
    always_comb begin
        busy_d  = start || (busy_q && !done);
        phase_d = busy_q ? phase_q + 2'd1 : phase_q;
        col_d   = busy_q && phase_q == 2'd3 ? col_q + 6'd1 : col_q;
        top_d   = busy_q && phase_q == 2'd0 ? rgb : top_q;
        pix_d   = busy_q && phase_q == 2'd1 ? {rgb, top_q} : pix_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q  <= 1'b1;
            col_q   <= '0;
            phase_q <= '0;
            top_q   <= '0;
            pix_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            top_q   <= top_d;
            pix_q   <= pix_d;
        end
    end
endmodule

// File: rtl/led_scanner.sv
// led_scanner: HUB75 64x64 1/32 scan engine driving the painter and the panel pins.
// LED_SCANNER_GHOST_SUPPRESS_EN lengthens SETTLE and zeroes the RGB pins while blanked.
module led_scanner
    import led_pkg::*;
#(
    parameter int DWELL_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [12:0] frame,
    output logic [5:0]  x,
    output logic [5:0]  y,
    input  logic [2:0]  rgb,
    output logic [15:0] LED_PANEL
);
    localparam int CW = $clog2(DWELL_CYCLES + SETTLE_LEN + 1);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    row_q, row_d, addr_q, addr_d;
    logic [12:0]   frame_q, frame_d;
    logic          oe_en_q, oe_en_d;
    logic          start, done, sclk, blank, lat, oe_n;
    logic [5:0]    pix, rgb_pins;

    led_pixel_sequencer u_seq (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .row    (row_q),
        .rgb    (rgb),
        .x      (x),
        .y      (y),
        .pix    (pix),
        .sclk   (sclk),
        .done   (done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        addr_d  = addr_q;
        frame_d = frame_q;
        oe_en_d = oe_en_q;
        start   = 1'b0;
        case (state_q)
            ST_SHIFT: if (done) begin
                state_d = DWELL_CYCLES > 0 ? ST_DWELL : ST_BLANK;
                cnt_d   = '0;
            end
            ST_DWELL: begin
                state_d = cnt_q == CW'(DWELL_CYCLES - 1) ? ST_BLANK : ST_DWELL;
                cnt_d   = cnt_q + 1'b1;
            end
            ST_BLANK: state_d = ST_LATCH;
            ST_LATCH: state_d = ST_ADDR;
            ST_ADDR: begin
                state_d = ST_SETTLE;
                addr_d  = row_q;
                row_d   = row_q + 5'd1;
                frame_d = row_q == 5'(SCAN_ROWS - 1) ? frame_q + 13'd1 : frame_q;
                oe_en_d = 1'b1;
                cnt_d   = '0;
            end
            ST_SETTLE: begin
                start   = cnt_q == CW'(SETTLE_LEN - 1);
                state_d = start ? ST_SHIFT : ST_SETTLE;
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_SHIFT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            frame_q <= '0;
            oe_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            frame_q <= frame_d;
            oe_en_q <= oe_en_d;
        end
    end

    // Output stays dark until a real row has been latched and addressed.
    assign blank = state_q inside {ST_BLANK, ST_LATCH, ST_ADDR, ST_SETTLE};
    assign lat   = state_q == ST_LATCH;
    assign oe_n  = blank || !oe_en_q;
    assign frame = frame_q;

`ifdef LED_SCANNER_GHOST_SUPPRESS_EN
    assign rgb_pins = blank ? 6'd0 : pix;
`else
    assign rgb_pins = pix;
`endif

    always_comb begin
        LED_PANEL                    = '0;
        LED_PANEL[LED_B1:LED_R0]     = rgb_pins;
        LED_PANEL[LED_E:LED_A]       = addr_q;
        LED_PANEL[LED_SCLK]          = sclk;
        LED_PANEL[LED_LAT]           = lat;
        LED_PANEL[LED_OE_N]          = oe_n;
    end
endmodule
